// File: rtl/lockin_magnitude_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lockin_magnitude_pkg
// Description : Shared types and width helpers for the lock-in magnitude
//               stage. These include the FSM state encoding, the square-sum
//               and remainder width functions, and the default output
//               saturation value.
// Revision    : 1.0  initial release
// ============================================================================
package lockin_magnitude_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SQ    = 3'd1,
        ROOT  = 3'd2,
        SCALE = 3'd3,
        OUT   = 3'd4
    } state_t;

    localparam int unsigned            OUT_W_DEF = 16;
    localparam logic [OUT_W_DEF-1:0]   OUT_MAX   = '1;

    // a*a + b*b for Q-bit magnitudes needs 2Q bits and never overflows
    function automatic int sum_w(input int q_in);
        return 2 * q_in;
    endfunction

    // restoring-root remainder is bounded by 2*root+1, which needs Q+2 bits after the 2-bit shift-in
    function automatic int rem_w(input int q_in);
        return q_in + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lockin_magnitude_isqrt_step.sv
`default_nettype none
// ============================================================================
// Module      : isqrt_step
// Description : One combinational iteration of a restoring integer square
//               root. It shifts the next two radicand bits into the
//               remainder, subtracts the trial value (root<<2)|1 when it
//               fits, and appends the resulting root bit.
// Ports       : rem_in/root_in  current partial remainder and root
//               bits_in         next two radicand bits (MSB first)
//               rem_out/root_out updated remainder and root
// Revision    : 1.0  initial release
// ============================================================================
module isqrt_step
    import lockin_magnitude_pkg::*;
#(
    parameter int Q_IN = 50
) (
    input  logic [rem_w(Q_IN)-1:0] rem_in,
    input  logic [Q_IN-1:0]        root_in,
    input  logic [1:0]             bits_in,
    output logic [rem_w(Q_IN)-1:0] rem_out,
    output logic [Q_IN-1:0]        root_out
);

    localparam int c_REM_W = rem_w(Q_IN);

    logic [c_REM_W-1:0] w_rem_sh;
    logic [c_REM_W-1:0] w_trial;
    logic               w_fits;

    assign w_rem_sh = (rem_in << 2) | c_REM_W'(bits_in);
    assign w_trial  = {root_in, 2'b01};
    assign w_fits   = (w_rem_sh >= w_trial);
    assign rem_out  = w_fits ? (w_rem_sh - w_trial) : w_rem_sh;
    assign root_out = (root_in << 1) | Q_IN'(w_fits);

endmodule
`default_nettype wire

// File: rtl/lockin_magnitude.sv
`default_nettype none
// ============================================================================
// Module      : lockin_magnitude
// Description : This module computes round(sqrt(fase^2 + cuad^2) / 2^SHIFT)
//               using a bit-serial restoring square root. It saturates the
//               result to OUT_W bits and presents it on a valid/ready output.
//               A job runs through IDLE -> SQ -> ROOT (Q_IN cycles) -> SCALE
//               -> OUT. out_valid rises Q_IN+2 edges after acceptance.
//               Build option: define AMP_ROUNDING_EN to round half up before
//               the shift. When it is undefined, the shift truncates.
// Ports       : clk, reset (sync, active-high)
//               fase, cuad, in_valid / in_ready    input handshake
//               amplitud, sat, out_valid / out_ready output handshake
// Revision    : 1.0  initial release
// ============================================================================
module lockin_magnitude
    import lockin_magnitude_pkg::*;
#(
    parameter int Q_IN  = 50,
    parameter int SHIFT = 24,
    parameter int OUT_W = $bits(OUT_MAX)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic signed [Q_IN-1:0] fase,
    input  logic signed [Q_IN-1:0] cuad,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [OUT_W-1:0]       amplitud,
    output logic                   sat,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int c_SUM_W = sum_w(Q_IN);
    localparam int c_REM_W = rem_w(Q_IN);
    localparam int c_CNT_W = $clog2(Q_IN);

    state_t              r_state;
    state_t              w_next;
    logic [Q_IN-1:0]     r_a;
    logic [Q_IN-1:0]     r_b;
    logic [c_SUM_W-1:0]  r_s;
    logic [c_REM_W-1:0]  r_rem;
    logic [Q_IN-1:0]     r_root;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [OUT_W-1:0]    r_amp;
    logic                r_sat;

    logic [Q_IN-1:0]     w_abs_f;
    logic [Q_IN-1:0]     w_abs_c;
    logic [c_REM_W-1:0]  w_rem_nx;
    logic [Q_IN-1:0]     w_root_nx;

    // |-2^(Q_IN-1)| wraps to the same bit pattern, which is the correct unsigned magnitude
    assign w_abs_f = fase[Q_IN-1] ? Q_IN'(-fase) : Q_IN'(fase);
    assign w_abs_c = cuad[Q_IN-1] ? Q_IN'(-cuad) : Q_IN'(cuad);

`ifdef AMP_ROUNDING_EN
    // one extra bit so the rounding carry can push the value into saturation
    localparam int c_V_W = Q_IN + 1;
    logic [c_V_W-1:0] w_v;
    assign w_v = ({1'b0, r_root} + (c_V_W'(1) << (SHIFT - 1))) >> SHIFT;
`else
    localparam int c_V_W = Q_IN;
    logic [c_V_W-1:0] w_v;
    assign w_v = r_root >> SHIFT;
`endif

    logic w_sat;
    assign w_sat = |w_v[c_V_W-1:OUT_W];

    isqrt_step #(
        .Q_IN     (Q_IN)
    ) u_step (
        .rem_in   (r_rem),
        .root_in  (r_root),
        .bits_in  (r_s[c_SUM_W-1 -: 2]),
        .rem_out  (w_rem_nx),
        .root_out (w_root_nx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)        w_next = SQ;
            SQ:                           w_next = ROOT;
            ROOT:    if (r_cnt == '0)     w_next = SCALE;
            SCALE:                        w_next = OUT;
            OUT:     if (out_ready)       w_next = IDLE;
            default:                      w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_s    <= '0;
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= '0;
            r_amp  <= '0;
            r_sat  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a <= w_abs_f;
                        r_b <= w_abs_c;
                    end
                end
                SQ: begin
                    r_s    <= c_SUM_W'(r_a) * c_SUM_W'(r_a) + c_SUM_W'(r_b) * c_SUM_W'(r_b);
                    r_rem  <= '0;
                    r_root <= '0;
                    r_cnt  <= c_CNT_W'(Q_IN - 1);
                end
                ROOT: begin
                    r_rem  <= w_rem_nx;
                    r_root <= w_root_nx;
                    r_s    <= r_s << 2;
                    r_cnt  <= r_cnt - 1'b1;
                end
                SCALE: begin
                    r_amp <= w_sat ? '1 : w_v[OUT_W-1:0];
                    r_sat <= w_sat;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == OUT);
    assign amplitud  = r_amp;
    assign sat       = r_sat;

endmodule
`default_nettype wire
